// File: rtl/tinyenc_pkg.sv
// Shared types and widths for the tinyenc byte-stream adapter.
package tinyenc_pkg;

    localparam int WORD_W = 32;
    localparam int BYTE_W = 8;
    localparam int IDX_W  = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2
    } enc_state_t;

endpackage

// File: rtl/tinyenc_byte_ser.sv
// 32-bit word to 8-bit valid/ready serializer, least-significant byte first.
module tinyenc_byte_ser
    import tinyenc_pkg::*;
(
    input  logic              clk,
    input  logic              rstb,
    input  logic              load,
    input  logic [WORD_W-1:0] load_data,
    output logic [BYTE_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready
);

    logic [WORD_W-1:0] obuf;
    logic [IDX_W-1:0]  k;
    logic              full;

    // Load a word, then step through its bytes on each accepted transfer.
    always_ff @(posedge clk or posedge rstb) begin
        if (rstb) begin
            obuf <= '0;
            k    <= '0;
            full <= 1'b0;
        end else if (load) begin
            obuf <= load_data;
            k    <= '0;
            full <= 1'b1;
        end else if (full && m_ready) begin
            if (k == 2'd3) begin
                k    <= '0;
                full <= 1'b0;
            end else begin
                k <= k + 2'd1;
            end
        end
    end

    // Byte select depends only on registered state, so m_data holds under stall.
    always_comb begin
        m_data = obuf[{k, 3'b000} +: BYTE_W];
    end

    assign m_valid = full;

endmodule

// File: rtl/tinyenc_stream.sv
// Byte-stream adapter around the tinyenc core: packs four bytes into a word,
// runs it through the core and serializes the result back out as bytes.
// Optional abort of a stuck core run: define TINYENC_STREAM_TIMEOUT_EN.
//
// state    | meaning
// ST_IDLE  | waiting for a full input word, idle core and empty output buffer
// ST_ISSUE | enc_write high for one cycle
// ST_BUSY  | waiting for the core to raise enc_valid
module tinyenc_stream
    import tinyenc_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic [BYTE_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [BYTE_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [WORD_W-1:0] enc_wdata,
    output logic              enc_write,
    input  logic              enc_valid,
    input  logic [WORD_W-1:0] enc_rdata,
    output logic              busy,
    output logic              err
);

    // The busy counter is 8 bits wide, so the abort threshold must fit in it.
    if (TIMEOUT < 1 || TIMEOUT > 256) begin : g_timeout_range
        $error("tinyenc_stream: TIMEOUT must be in 1..256");
    end

    enc_state_t        state;
    logic [IDX_W-1:0]  in_cnt;
    logic [WORD_W-1:0] in_word;
    logic              in_full;
    logic              out_full;
    logic              issue_go;
    logic              capture;
    logic              s_fire;

`ifdef TINYENC_STREAM_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
    logic [7:0] tmo_cnt;
`else
    assign err = 1'b0;
`endif

    assign s_ready  = !in_full;
    assign s_fire   = s_valid && s_ready;
    assign issue_go = (state == ST_IDLE) && in_full && enc_valid && !out_full;
    assign capture  = (state == ST_BUSY) && enc_valid;
    assign busy     = (state != ST_IDLE);

    // Input collector: little-endian packing; handing the word off frees it.
    always_ff @(posedge clk or posedge rstb) begin
        if (rstb) begin
            in_cnt  <= '0;
            in_word <= '0;
            in_full <= 1'b0;
        end else begin
            if (issue_go) begin
                in_full <= 1'b0;
            end
            if (s_fire) begin
                in_word[{in_cnt, 3'b000} +: BYTE_W] <= s_data;
                in_cnt <= in_cnt + 2'd1;
                if (in_cnt == 2'd3) begin
                    in_full <= 1'b1;
                end
            end
        end
    end

    // Core sequencing FSM with registered load pulse and word.
    always_ff @(posedge clk or posedge rstb) begin
        if (rstb) begin
            state     <= ST_IDLE;
            enc_write <= 1'b0;
            enc_wdata <= '0;
`ifdef TINYENC_STREAM_TIMEOUT_EN
            tmo_cnt   <= '0;
            err       <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    enc_write <= 1'b0;
                    if (issue_go) begin
                        enc_wdata <= in_word;
                        enc_write <= 1'b1;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    enc_write <= 1'b0;
                    state     <= ST_BUSY;
`ifdef TINYENC_STREAM_TIMEOUT_EN
                    tmo_cnt   <= '0;
`endif
                end
                ST_BUSY: begin
                    enc_write <= 1'b0;
                    if (enc_valid) begin
                        state <= ST_IDLE;
                    end
`ifdef TINYENC_STREAM_TIMEOUT_EN
                    // Abandon the word; any result already buffered is kept.
                    else if (tmo_cnt == TMO_LAST) begin
                        err   <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
`endif
                end
                default: begin
                    enc_write <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

    tinyenc_byte_ser u_out_ser (
        .clk       (clk),
        .rstb      (rstb),
        .load      (capture),
        .load_data (enc_rdata),
        .m_data    (m_data),
        .m_valid   (out_full),
        .m_ready   (m_ready)
    );

    assign m_valid = out_full;

endmodule
